// File: rtl/and_32_bit_if.sv
// Operand/result bundle for the 32-bit AND unit.
// The master drives operands and in_valid; the slave returns the combinational and registered results.
interface and_32_bit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic [31:0] and_comb;
    logic [31:0] result;
    logic        out_valid;
    logic        zero;

    modport master (
        output a,
        output b,
        output in_valid,
        input  and_comb,
        input  result,
        input  out_valid,
        input  zero
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output and_comb,
        output result,
        output out_valid,
        output zero
    );
endinterface

// File: rtl/and_32_bit.sv
// Bitwise 32-bit AND unit for the ALU datapath: one gate per bit lane,
// plus a one-cycle registered copy of the result with valid and zero flags.
module and_gate_1_bit (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module and_32_bit (
    input  logic        clk,
    input  logic        reset,
    and_32_bit_if.slave bus
);
    localparam int WIDTH = 32;

    logic [WIDTH-1:0] and_w;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             zero_q;
    logic             zero_d;
    logic             out_valid_q;
    logic             out_valid_d;

    // Independent bit lanes: no carries or cross-bit logic.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        and_gate_1_bit u_gate (
            .a_i (bus.a[i]),
            .b_i (bus.b[i]),
            .y_o (and_w[i])
        );
    end

    // Handshake: in_valid is sampled on each rising clk; no ready, so the unit
    // accepts every cycle. out_valid pulses for exactly the cycle after a capture,
    // while result/zero hold the last captured value when nothing new arrives.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            result_d = and_w;
            zero_d   = (and_w == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.and_comb  = and_w;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_and_32_bit.sv
// Self-checking bench for and_32_bit: directed cases, hold, async reset,
// and randomized back-to-back traffic against a bitwise reference model.
module tb_and_32_bit;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    logic [31:0] exp_q[$];

    and_32_bit_if bus ();

    and_32_bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: built bit by bit from the truth table of a 2-input AND.
    function automatic logic [31:0] model_and(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = (x[i] == 1'b1 && y[i] == 1'b1) ? 1'b1 : 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.in_valid = 1'b1;
        tick();
        tests_run++;
        if (bus.result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0);
        end
        tests_run++;
        if (bus.zero !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got zero=%b valid=%b expected zero=1 valid=0", bus.zero, bus.out_valid);
        end
        tests_run++;
        if (bus.and_comb !== model_and(bus.a, bus.b)) begin
            tests_failed++;
            $display("FAIL reset_and_comb: got %h expected %h", bus.and_comb, model_and(bus.a, bus.b));
        end
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] ta[4];
        logic [31:0] tb[4];
        logic [31:0] tr[4];
        logic        tz[4];
        ta = '{32'h0000_0000, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
        tb = '{32'h0000_0000, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
        tr = '{32'h0000_0000, 32'hAAAA_AAAA, 32'h0000_0000, 32'hFFFF_FFFF};
        tz = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            bus.a        = ta[k];
            bus.b        = tb[k];
            bus.in_valid = 1'b1;
            #1;
            tests_run++;
            if (bus.and_comb !== tr[k]) begin
                tests_failed++;
                $display("FAIL directed%0d_and_comb: got %h expected %h", k, bus.and_comb, tr[k]);
            end
            tick();
            tests_run++;
            if (bus.result !== tr[k] || bus.zero !== tz[k] || bus.out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL directed%0d_reg: got %h z=%b v=%b expected %h z=%b v=1",
                         k, bus.result, bus.zero, bus.out_valid, tr[k], tz[k]);
            end
        end
    endtask

    task automatic test_hold();
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        tick();
        bus.a        = 32'h0;
        bus.b        = 32'h0;
        bus.in_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.and_comb !== 32'h0) begin
            tests_failed++;
            $display("FAIL hold_and_comb: got %h expected %h", bus.and_comb, 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (bus.result !== 32'hFFFF_FFFF || bus.out_valid !== 1'b0 || bus.zero !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_reg: got %h v=%b z=%b expected ffffffff v=0 z=0",
                         bus.result, bus.out_valid, bus.zero);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h z=%b v=%b expected 00000000 z=1 v=0",
                     bus.result, bus.zero, bus.out_valid);
        end
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.a        = 32'h1234_5678;
        bus.b        = 32'hFFFF_0000;
        bus.in_valid = 1'b1;
        #1;
        reset = 1'b1;
        tick();
        tests_run++;
        if (bus.result !== 32'h0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midstream_discard: got %h v=%b expected 00000000 v=0", bus.result, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
            tests_failed++;
            $display("FAIL midstream_idle: got %h v=%b expected 00000000 v=0", bus.result, bus.out_valid);
        end
        bus.a        = 32'hF0F0_1234;
        bus.b        = 32'h0FF0_FFFF;
        bus.in_valid = 1'b1;
        tick();
        tests_run++;
        if (bus.result !== 32'h00F0_1234 || bus.out_valid !== 1'b1 || bus.zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL midstream_first: got %h v=%b z=%b expected 00f01234 v=1 z=0",
                     bus.result, bus.out_valid, bus.zero);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_res;
        logic [31:0] exp_r;
        logic        exp_v;
        last_res = bus.result;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: begin bus.a = $urandom; bus.b = ~bus.a; end
                1: begin bus.a = $urandom; bus.b = 32'hFFFF_FFFF; end
                default: begin bus.a = $urandom; bus.b = $urandom; end
            endcase
            bus.in_valid = (n < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            tests_run++;
            if (bus.and_comb !== model_and(bus.a, bus.b)) begin
                tests_failed++;
                $display("FAIL b2b_and_comb: got %h expected %h", bus.and_comb, model_and(bus.a, bus.b));
            end
            exp_v = bus.in_valid;
            if (bus.in_valid) exp_q.push_back(model_and(bus.a, bus.b));
            tick();
            if (exp_v) exp_r = exp_q.pop_front();
            else       exp_r = last_res;
            last_res = exp_r;
            tests_run++;
            if (bus.result !== exp_r || bus.out_valid !== exp_v || bus.zero !== (exp_r == 32'h0)) begin
                tests_failed++;
                $display("FAIL b2b_reg: got %h v=%b z=%b expected %h v=%b z=%b",
                         bus.result, bus.out_valid, bus.zero, exp_r, exp_v, (exp_r == 32'h0));
            end
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_queue: got %0d leftover expected 0", exp_q.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.a        = 32'h0;
        bus.b        = 32'h0;
        bus.in_valid = 1'b0;
        #3;
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_reset_midstream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
